mem_port_arbiter: RTL

Sequential arbiter that shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the MIPS pipeline. It accepts level-held requests from both stages and grants one at a time. It drives the memory with latched address and data, waits for the memory's ready strobe, and returns a one-cycle acknowledge with registered read data. It also produces the stall signals the pipeline controller uses to freeze IF and MEM while they wait, and it aborts hung accesses with a sticky error flag.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports, memory port and status of the IF/MEM memory arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and MEM stages
// with alternating priority under contention, one-cycle acks and a sticky timeout flag.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t           state, state_n;
    logic             last_d;
    logic [CNT_W-1:0] cnt;
    logic             if_pend, d_pend, grant_d, grant_if, done, tout;

    assign bus.mem_en    = state != IDLE;
    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = (bus.d_read | bus.d_write) & ~bus.d_ack;

    // a port whose ack is high this cycle is masked so it is not regranted at once
    always_comb begin
        if_pend  = bus.if_req & ~bus.if_ack;
        d_pend   = (bus.d_read | bus.d_write) & ~bus.d_ack;
        grant_d  = d_pend & (~if_pend | ~last_d);
        grant_if = if_pend & ~grant_d;
        done     = (state != IDLE) & bus.mem_ready;
        tout     = (state != IDLE) & ~bus.mem_ready & (cnt == CNT_W'(TIMEOUT - 1));
        state_n  = state;
        if (state == IDLE)
            state_n = grant_d ? D_BUSY : grant_if ? IF_BUSY : IDLE;
        else if (done | tout)
            state_n = IDLE;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d        <= 1'b0;
            cnt           <= '0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.if_ack <= (state == IF_BUSY) & (done | tout);
            bus.d_ack  <= (state == D_BUSY) & (done | tout);
            bus.err    <= bus.err | tout;
            if (state == IDLE && (grant_d || grant_if)) begin
                bus.mem_addr  <= grant_d ? bus.d_addr : bus.if_addr;
                bus.mem_wdata <= bus.d_wdata;
                bus.mem_we    <= grant_d & bus.d_write;
                last_d        <= grant_d;
                cnt           <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(cnt != CNT_W'(TIMEOUT));
            end
            if (state == IF_BUSY && (done || tout))
                bus.if_rdata <= done ? bus.mem_rdata : '0;
            if (state == D_BUSY && tout)
                bus.d_rdata <= '0;
            else if (state == D_BUSY && done && !bus.mem_we)
                bus.d_rdata <= bus.mem_rdata;
        end
    end
endmodule
